// File: rtl/player_pkg.sv
// Shared types and playfield constants for the player motion controller.
package player_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_STUNNED = 2'd1,
    ST_EXPIRED = 2'd2
  } stun_state_t;

  localparam int unsigned X_MIN_PX = 144;
  localparam int unsigned X_MAX_PX = 660;
  localparam int unsigned Y_MIN_PX = 35;
  localparam int unsigned Y_MAX_PX = 515;

  localparam int unsigned BLK_LEFT  = 0;
  localparam int unsigned BLK_RIGHT = 1;
  localparam int unsigned BLK_DOWN  = 2;
  localparam int unsigned BLK_UP    = 3;

endpackage

// File: rtl/player_motion_ctrl_tick_divider.sv
// Wrapping divide-by-DIV counter; tick is high on the cycle it wraps.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player position, stun FSM and blocker proximity flags.
// Build option: PLAYER_DIAGONAL_EN lets both axes move on one tick.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int unsigned PLAYER_RADIUS = 25,
  parameter int unsigned INIT_X        = 400,
  parameter int unsigned INIT_Y        = 300,
  parameter int unsigned X_MIN         = X_MIN_PX,
  parameter int unsigned X_MAX         = X_MAX_PX,
  parameter int unsigned Y_MIN         = Y_MIN_PX,
  parameter int unsigned Y_MAX         = Y_MAX_PX,
  parameter int unsigned STEP_DIV      = 200000,
  parameter int unsigned CLK_PER_SEC   = 50000000,
  parameter int unsigned STUN_SECONDS  = 10,
  parameter int unsigned NUM_BLOCKERS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_left_n,
  input  logic                      btn_right_n,
  input  logic                      btn_up_n,
  input  logic                      btn_down_n,
  input  logic                      bludged,
  input  logic [10*NUM_BLOCKERS-1:0] blk_x,
  input  logic [10*NUM_BLOCKERS-1:0] blk_y,
  output logic [9:0]                pos_x,
  output logic [9:0]                pos_y,
  output logic [4:0]                stun_time,
  output logic                      stun_done,
  output logic [3:0]                blocked
);

  localparam coord_t X_LO = coord_t'(X_MIN + PLAYER_RADIUS);
  localparam coord_t X_HI = coord_t'(X_MAX - PLAYER_RADIUS);
  localparam coord_t Y_LO = coord_t'(Y_MIN + PLAYER_RADIUS);
  localparam coord_t Y_HI = coord_t'(Y_MAX - PLAYER_RADIUS);
  localparam logic [20:0] NEAR2 =
    21'((2*PLAYER_RADIUS + 2) * (2*PLAYER_RADIUS + 2));
  localparam logic [4:0] STUN_INIT = 5'(STUN_SECONDS);

  stun_state_t state_q, state_d;
  coord_t      pos_x_q, pos_x_d;
  coord_t      pos_y_q, pos_y_d;
  logic [4:0]  stun_q, stun_d;
  logic        done_q, done_d;
  logic [3:0]  blocked_q, blocked_d;
  logic        step_tick, sec_tick;
  logic        stunned;

  assign stunned = (state_q == ST_STUNNED);

  tick_divider #(.DIV(STEP_DIV)) u_step_div (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .clr  (1'b0),
    .tick (step_tick)
  );

  tick_divider #(.DIV(CLK_PER_SEC)) u_sec_div (
    .clk  (clk),
    .rst  (rst),
    .en   (stunned),
    .clr  (!stunned),
    .tick (sec_tick)
  );

  always_comb begin
    coord_t      bx, by, dx, dy;
    logic [20:0] dist2;
    bx        = '0;
    by        = '0;
    dx        = '0;
    dy        = '0;
    dist2     = '0;
    blocked_d = '0;
    for (int i = 0; i < NUM_BLOCKERS; i++) begin
      bx    = blk_x[10*i +: 10];
      by    = blk_y[10*i +: 10];
      dx    = (pos_x_q > bx) ? pos_x_q - bx : bx - pos_x_q;
      dy    = (pos_y_q > by) ? pos_y_q - by : by - pos_y_q;
      dist2 = 21'(dx) * 21'(dx) + 21'(dy) * 21'(dy);
      if (dist2 < NEAR2) begin
        if (pos_x_q > bx) blocked_d[BLK_LEFT]  = 1'b1;
        else              blocked_d[BLK_RIGHT] = 1'b1;
        if (pos_y_q > by) blocked_d[BLK_UP]    = 1'b1;
        else              blocked_d[BLK_DOWN]  = 1'b1;
      end
    end
    if (state_q != ST_FREE)
      blocked_d = 4'hF;
  end

  always_comb begin
    logic req_r, req_l, req_u, req_d, v_en;
    req_r = !btn_right_n && btn_left_n;
    req_l = !btn_left_n  && btn_right_n;
    req_d = !btn_down_n  && btn_up_n;
    req_u = !btn_up_n    && btn_down_n;
`ifdef PLAYER_DIAGONAL_EN
    v_en = 1'b1;
`else
    v_en = !(req_r || req_l);
`endif
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (state_q == ST_FREE && step_tick) begin
      if (req_r && !blocked_q[BLK_RIGHT] && pos_x_q < X_HI)
        pos_x_d = pos_x_q + 1'b1;
      else if (req_l && !blocked_q[BLK_LEFT] && pos_x_q > X_LO)
        pos_x_d = pos_x_q - 1'b1;
      if (v_en) begin
        if (req_d && !blocked_q[BLK_DOWN] && pos_y_q < Y_HI)
          pos_y_d = pos_y_q + 1'b1;
        else if (req_u && !blocked_q[BLK_UP] && pos_y_q > Y_LO)
          pos_y_d = pos_y_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    stun_d  = stun_q;
    done_d  = done_q;
    unique case (state_q)
      ST_FREE: begin
        stun_d = STUN_INIT;
        done_d = 1'b0;
        if (bludged) state_d = ST_STUNNED;
      end
      ST_STUNNED: begin
        if (!bludged) begin
          state_d = ST_FREE;
          stun_d  = STUN_INIT;
        end else if (sec_tick) begin
          stun_d = (stun_q == 5'd0) ? 5'd0 : stun_q - 1'b1;
          // Expire on the same edge that reaches zero
          if (stun_q <= 5'd1) begin
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
          end
        end
      end
      ST_EXPIRED: begin
        if (!bludged) begin
          state_d = ST_FREE;
          stun_d  = STUN_INIT;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      pos_x_q   <= coord_t'(INIT_X);
      pos_y_q   <= coord_t'(INIT_Y);
      stun_q    <= STUN_INIT;
      done_q    <= 1'b0;
      blocked_q <= 4'h0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      stun_q    <= stun_d;
      done_q    <= done_d;
      blocked_q <= blocked_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign stun_time = stun_q;
  assign stun_done = done_q;
  assign blocked   = blocked_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: motion, edges, blockers, stun.
// Expected vertical diagonal result follows PLAYER_DIAGONAL_EN.
module tb_player_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_left_n = 1'b1;
  logic        btn_right_n = 1'b1;
  logic        btn_up_n = 1'b1;
  logic        btn_down_n = 1'b1;
  logic        bludged = 1'b0;
  logic [19:0] blk_x = {10'd1023, 10'd1023};
  logic [19:0] blk_y = {10'd1023, 10'd1023};
  logic [9:0]  pos_x, pos_y;
  logic [4:0]  stun_time;
  logic        stun_done;
  logic [3:0]  blocked;

  int errs = 0;
  int checks = 0;

  player_motion_ctrl #(
    .STEP_DIV     (4),
    .CLK_PER_SEC  (8),
    .STUN_SECONDS (3),
    .NUM_BLOCKERS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_left_n  (btn_left_n),
    .btn_right_n (btn_right_n),
    .btn_up_n    (btn_up_n),
    .btn_down_n  (btn_down_n),
    .bludged     (bludged),
    .blk_x       (blk_x),
    .blk_y       (blk_y),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .stun_time   (stun_time),
    .stun_done   (stun_done),
    .blocked     (blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_btns();
    btn_left_n  = 1'b1;
    btn_right_n = 1'b1;
    btn_up_n    = 1'b1;
    btn_down_n  = 1'b1;
  endtask

  initial begin
    int exp_y;

    step(2);
    chk("rst_x", pos_x, 400);
    chk("rst_y", pos_y, 300);
    chk("rst_stun", stun_time, 3);
    chk("rst_done", stun_done, 0);
    chk("rst_blk", blocked, 0);
    rst = 1'b0;

    btn_right_n = 1'b0;
    step(40);
    release_btns();
    chk("right40_x", pos_x, 410);
    chk("right40_y", pos_y, 300);

    btn_right_n = 1'b0;
    btn_down_n  = 1'b0;
    step(4);
    release_btns();
`ifdef PLAYER_DIAGONAL_EN
    exp_y = 301;
`else
    exp_y = 300;
`endif
    chk("diag_x", pos_x, 411);
    chk("diag_y", pos_y, exp_y);

    btn_left_n  = 1'b0;
    btn_right_n = 1'b0;
    step(8);
    release_btns();
    chk("both_lr_x", pos_x, 411);

    btn_left_n = 1'b0;
    step(4 * (242 + 20));
    release_btns();
    chk("left_edge_x", pos_x, 169);
    chk("left_edge_y", pos_y, exp_y);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst2_x", pos_x, 400);
    blk_x[9:0] = 10'd440;
    blk_y[9:0] = 10'd300;
    btn_left_n = 1'b0;
    step(48);
    release_btns();
    chk("near_walk_x", pos_x, 388);
    step(1);
    chk("dist52_blk", blocked, 4'b0000);
    btn_right_n = 1'b0;
    step(4);
    chk("dist52_step_x", pos_x, 389);
    step(1);
    chk("dist51_blk", blocked, 4'b0110);
    step(20);
    chk("blocked_hold_x", pos_x, 389);
    release_btns();
    btn_left_n = 1'b0;
    step(8);
    release_btns();
    chk("away_left_x", pos_x, 387);
    blk_x[9:0] = 10'd1023;
    blk_y[9:0] = 10'd1023;

    bludged = 1'b1;
    step(1);
    chk("stun_entry_t", stun_time, 3);
    chk("stun_entry_d", stun_done, 0);
    btn_right_n = 1'b0;
    step(7);
    chk("stun_t3_hold", stun_time, 3);
    step(1);
    chk("stun_t2", stun_time, 2);
    step(8);
    chk("stun_t1", stun_time, 1);
    step(8);
    chk("stun_t0", stun_time, 0);
    chk("stun_done", stun_done, 1);
    step(5);
    chk("exp_t", stun_time, 0);
    chk("exp_done", stun_done, 1);
    chk("exp_blk", blocked, 4'hF);
    chk("stun_nomove_x", pos_x, 387);
    release_btns();

    bludged = 1'b0;
    step(1);
    chk("exp_free_t", stun_time, 3);
    chk("exp_free_d", stun_done, 0);

    bludged = 1'b1;
    step(1);
    step(8);
    chk("mid_t2", stun_time, 2);
    bludged = 1'b0;
    step(1);
    chk("mid_free_t", stun_time, 3);
    chk("mid_free_d", stun_done, 0);
    step(1);
    chk("mid_free_blk", blocked, 0);
    btn_right_n = 1'b0;
    step(4);
    release_btns();
    chk("mid_free_move", pos_x, 388);

    bludged = 1'b1;
    step(10);
    chk("pre_rst_t", stun_time, 2);
    rst = 1'b1;
    step(1);
    chk("rst3_x", pos_x, 400);
    chk("rst3_y", pos_y, 300);
    chk("rst3_t", stun_time, 3);
    chk("rst3_d", stun_done, 0);
    chk("rst3_blk", blocked, 0);
    rst = 1'b0;
    bludged = 1'b0;
    btn_right_n = 1'b0;
    step(4);
    release_btns();
    chk("rst3_free_move", pos_x, 401);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
